// File: rtl/rf_pkg.sv
// Shared types and widths for the register-file writeback scheduler.
// Pure declarations; no logic, no latency, no backpressure.
package rf_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] reg_a;
        logic [DATA_W-1:0]     data;
    } wb_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr.
// Grant is combinational (0 cycles); a requester waits while another holds the grant.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);
    localparam int PTR_W = $clog2(N);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_nxt;
    int               idx;

    // Walk offsets from farthest to nearest so the nearest valid requester wins.
    always_comb begin
        grant   = '0;
        ptr_nxt = ptr;
        idx     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                idx = (int'(ptr) + k) % N;
            end
        end
        if (|req) begin
            grant   = N'(1) << idx;
            ptr_nxt = (idx == N - 1) ? '0 : PTR_W'(idx + 1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (|req) begin
            ptr <= ptr_nxt;
        end
    end
endmodule

// File: rtl/rf_write_sched.sv
// Schedules N_REQ writeback sources onto the single RF write port, tracks pending writes.
// Write port is registered: transfer at edge k drives the RF during cycle k+1; one write/cycle max.
// Losers of arbitration see req_ready=0 and hold. Optional RF_WB_STATS_EN adds conflict_cnt.
module rf_write_sched
    import rf_pkg::*;
#(
    parameter int N_REQ = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        reserve_en,
    input  logic [REG_ADDR_W-1:0]       reserve_reg,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*REG_ADDR_W-1:0] req_reg,
    input  logic [N_REQ*DATA_W-1:0]     req_data,
    output logic [N_REQ-1:0]            req_ready,
`ifdef RF_WB_STATS_EN
    output logic [31:0]                 conflict_cnt,
`endif
    output logic                        rf_write_en,
    output logic [REG_ADDR_W-1:0]       rf_write_reg,
    output logic [DATA_W-1:0]           rf_write_data,
    output logic [NUM_REGS-1:0]         busy_vec
);
    logic [N_REQ-1:0]    arb_req;
    logic [N_REQ-1:0]    grant;
    logic                xfer;
    wb_req_t             sel;
    logic [NUM_REGS-1:0] busy_nxt;

    // Masking requests in reset keeps ready low without a second gate on the output.
    assign arb_req   = rst_n ? req_valid : '0;
    assign req_ready = grant;
    assign xfer      = |grant;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (arb_req),
        .grant (grant)
    );

    always_comb begin
        sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel.reg_a = req_reg[REG_ADDR_W*i +: REG_ADDR_W];
                sel.data  = req_data[DATA_W*i +: DATA_W];
            end
        end
    end

    // Set is applied after clear so a same-cycle reserve of the committed register wins.
    always_comb begin
        busy_nxt = busy_vec;
        if (xfer && sel.reg_a != '0) begin
            busy_nxt[sel.reg_a] = 1'b0;
        end
        if (reserve_en && reserve_reg != '0) begin
            busy_nxt[reserve_reg] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_write_en   <= 1'b0;
            rf_write_reg  <= '0;
            rf_write_data <= '0;
            busy_vec      <= '0;
        end else begin
            busy_vec    <= busy_nxt;
            rf_write_en <= xfer && (sel.reg_a != '0);
            if (xfer && sel.reg_a != '0) begin
                rf_write_reg  <= sel.reg_a;
                rf_write_data <= sel.data;
            end
        end
    end

`ifdef RF_WB_STATS_EN
    logic multi_req;
    assign multi_req = (req_valid & (req_valid - 1'b1)) != '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (multi_req && conflict_cnt != 32'hFFFF_FFFF) begin
            conflict_cnt <= conflict_cnt + 32'd1;
        end
    end
`endif
endmodule
